// File: rtl/count_mon_pkg.sv
// Shared types and helpers for the count sequencing monitor and its formal harness.
package count_mon_pkg;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_SKIP       = 2'd1,
    ERR_EARLY_WRAP = 2'd2,
    ERR_STUCK      = 2'd3
  } err_code_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_FAULT = 2'd2
  } mon_state_e;

  // Increment v, holding at the all-ones value of a w-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/count_step_classifier.sv
// Classifies one count step (prev -> count) as legal, legal wrap, or a violation type.
module count_step_classifier
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] prev_i,
  input  logic [WIDTH-1:0] count_i,
  output logic             legal_o,
  output logic             is_wrap_o,
  output err_code_e        code_o
);

  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic stuck;
  logic step_ok;

  assign stuck   = (count_i == prev_i);
  assign step_ok = (count_i == WIDTH'(prev_i + WIDTH'(1)));

  // Priority: stuck, then +1, then premature zero, else skip.
  always_comb begin
    code_o = ERR_NONE;
    if (stuck) begin
      code_o = ERR_STUCK;
    end else if (step_ok) begin
      code_o = ERR_NONE;
    end else if (count_i == '0) begin
      code_o = ERR_EARLY_WRAP;
    end else begin
      code_o = ERR_SKIP;
    end
  end

  assign legal_o   = !stuck && step_ok;
  assign is_wrap_o = legal_o && (prev_i == MAX_VAL);

endmodule

// File: rtl/count_seq_monitor.sv
// Runtime monitor checking that an upstream counter steps by +1 with legal wrap only at MAX.
module count_seq_monitor
  import count_mon_pkg::*;
#(
  parameter int unsigned WIDTH      = 4,
  parameter int unsigned WRAP_CNT_W = 8,
  parameter int unsigned ERR_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      count_in_i,
  input  logic                  count_vld_i,
  input  logic                  clear_err_i,
  output logic                  err_o,
  output logic [1:0]            err_code_o,
  output logic [WIDTH-1:0]      bad_value_o,
  output logic [WIDTH-1:0]      bad_prev_o,
  output logic [ERR_CNT_W-1:0]  err_cnt_o,
  output logic                  wrap_pulse_o,
  output logic [WRAP_CNT_W-1:0] wrap_cnt_o
);

  mon_state_e            state_q;
  logic [WIDTH-1:0]      prev_q;
  logic                  err_q;
  err_code_e             err_code_q;
  logic [WIDTH-1:0]      bad_value_q;
  logic [WIDTH-1:0]      bad_prev_q;
  logic [ERR_CNT_W-1:0]  err_cnt_q;
  logic [ERR_CNT_W-1:0]  err_cnt_d;
  logic                  wrap_pulse_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_q;
  logic [WRAP_CNT_W-1:0] wrap_cnt_d;

  logic      step_legal;
  logic      step_wrap;
  err_code_e step_code;

  count_step_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .prev_i   (prev_q),
    .count_i  (count_in_i),
    .legal_o  (step_legal),
    .is_wrap_o(step_wrap),
    .code_o   (step_code)
  );

  assign err_cnt_d  = ERR_CNT_W'(sat_inc(32'(err_cnt_q), ERR_CNT_W));
  assign wrap_cnt_d = WRAP_CNT_W'(sat_inc(32'(wrap_cnt_q), WRAP_CNT_W));

  // Sequencing FSM; a sample coincident with clear_err is dropped and IDLE re-primes prev.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prev_q       <= '0;
      err_q        <= 1'b0;
      err_code_q   <= ERR_NONE;
      bad_value_q  <= '0;
      bad_prev_q   <= '0;
      err_cnt_q    <= '0;
      wrap_pulse_q <= 1'b0;
      wrap_cnt_q   <= '0;
    end else begin
      wrap_pulse_q <= 1'b0;
      if (clear_err_i) begin
        state_q     <= ST_IDLE;
        err_q       <= 1'b0;
        err_code_q  <= ERR_NONE;
        bad_value_q <= '0;
        bad_prev_q  <= '0;
        err_cnt_q   <= '0;
      end else if (count_vld_i) begin
        prev_q <= count_in_i;
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_TRACK;
          end
          ST_TRACK: begin
            if (step_legal) begin
              if (step_wrap) begin
                wrap_pulse_q <= 1'b1;
                wrap_cnt_q   <= wrap_cnt_d;
              end
            end else begin
              state_q     <= ST_FAULT;
              err_q       <= 1'b1;
              err_code_q  <= step_code;
              bad_value_q <= count_in_i;
              bad_prev_q  <= prev_q;
              err_cnt_q   <= ERR_CNT_W'(1);
            end
          end
          ST_FAULT: begin
            if (step_legal) begin
              if (step_wrap) begin
                wrap_pulse_q <= 1'b1;
                wrap_cnt_q   <= wrap_cnt_d;
              end
            end else begin
              err_cnt_q <= err_cnt_d;
            end
          end
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign err_o        = err_q;
  assign err_code_o   = err_code_q;
  assign bad_value_o  = bad_value_q;
  assign bad_prev_o   = bad_prev_q;
  assign err_cnt_o    = err_cnt_q;
  assign wrap_pulse_o = wrap_pulse_q;
  assign wrap_cnt_o   = wrap_cnt_q;

endmodule

// File: tb/tb_count_seq_monitor.sv
// Bench for count_seq_monitor: directed scenarios plus random traffic against a behavioural model.
module tb_count_seq_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] count_in = '0;
  logic       count_vld = 1'b0;
  logic       clear_err = 1'b0;
  logic       err;
  logic [1:0] err_code;
  logic [3:0] bad_value;
  logic [3:0] bad_prev;
  logic [3:0] err_cnt;
  logic       wrap_pulse;
  logic [7:0] wrap_cnt;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Model state
  bit m_primed = 1'b0;
  int m_prev = 0;
  int m_err = 0, m_code = 0, m_bv = 0, m_bp = 0, m_ecnt = 0, m_pulse = 0, m_wcnt = 0;

  int last_v = 0;
  int pulses = 0;
  int saved_wcnt = 0;

  always #5 clk = ~clk;

  count_seq_monitor #(.WIDTH(4), .WRAP_CNT_W(8), .ERR_CNT_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .count_in_i  (count_in),
    .count_vld_i (count_vld),
    .clear_err_i (clear_err),
    .err_o       (err),
    .err_code_o  (err_code),
    .bad_value_o (bad_value),
    .bad_prev_o  (bad_prev),
    .err_cnt_o   (err_cnt),
    .wrap_pulse_o(wrap_pulse),
    .wrap_cnt_o  (wrap_cnt)
  );

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: rules applied to the inputs seen at each rising edge.
  always @(posedge clk) begin
    int t;
    m_pulse = 0;
    if (rst) begin
      m_primed = 0; m_prev = 0; m_err = 0; m_code = 0; m_bv = 0; m_bp = 0;
      m_ecnt = 0; m_wcnt = 0;
    end else if (clear_err) begin
      m_primed = 0; m_err = 0; m_code = 0; m_bv = 0; m_bp = 0; m_ecnt = 0;
    end else if (count_vld) begin
      if (!m_primed) begin
        m_primed = 1;
      end else begin
        if (int'(count_in) == m_prev) t = 3;
        else if (int'(count_in) == (m_prev + 1) % 16) t = 0;
        else if (count_in == 4'd0) t = 2;
        else t = 1;
        if (t == 0) begin
          if (m_prev == 15) begin
            m_pulse = 1;
            if (m_wcnt < 255) m_wcnt++;
          end
        end else if (m_err == 0) begin
          m_err = 1; m_code = t; m_bv = int'(count_in); m_bp = m_prev; m_ecnt = 1;
        end else if (m_ecnt < 15) begin
          m_ecnt++;
        end
      end
      m_prev = int'(count_in);
    end
  end

  // Cycle-by-cycle comparison, half a period after each edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("err", 32'(err), m_err);
      chk("err_code", 32'(err_code), m_code);
      chk("bad_value", 32'(bad_value), m_bv);
      chk("bad_prev", 32'(bad_prev), m_bp);
      chk("err_cnt", 32'(err_cnt), m_ecnt);
      chk("wrap_pulse", 32'(wrap_pulse), m_pulse);
      chk("wrap_cnt", 32'(wrap_cnt), m_wcnt);
    end
  end

  task automatic cyc(input bit vld, input int v, input bit clr);
    count_vld = vld;
    count_in  = 4'(v);
    clear_err = clr;
    if (vld) last_v = v;
    @(negedge clk);
    if (wrap_pulse) pulses++;
    count_vld = 1'b0;
    clear_err = 1'b0;
  endtask

  task automatic samp(input int v);
    cyc(1'b1, v, 1'b0);
  endtask

  task automatic clr();
    cyc(1'b0, 0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_err", 32'(err), 0);
    chk("rst_wrap_cnt", 32'(wrap_cnt), 0);
    rst = 1'b0;

    // Full legal sweep with one wrap
    pulses = 0;
    for (int i = 0; i < 16; i++) samp(i);
    samp(0);
    chk("sweep_pulse_on_zero", 32'(wrap_pulse), 1);
    samp(1);
    chk("sweep_err", 32'(err), 0);
    chk("sweep_code", 32'(err_code), 0);
    chk("sweep_pulses", pulses, 1);
    chk("sweep_wrap_cnt", 32'(wrap_cnt), 1);

    // Early wrap
    clr();
    samp(12); samp(13); samp(14);
    chk("ew_err_before", 32'(err), 0);
    samp(0);
    chk("ew_err", 32'(err), 1);
    chk("ew_code", 32'(err_code), 2);
    chk("ew_bad_value", 32'(bad_value), 0);
    chk("ew_bad_prev", 32'(bad_prev), 14);
    chk("ew_err_cnt", 32'(err_cnt), 1);
    chk("ew_pulse", 32'(wrap_pulse), 0);

    // Skip, then a second skip in FAULT
    clr();
    samp(3); samp(5);
    chk("skip_code", 32'(err_code), 1);
    chk("skip_bad_value", 32'(bad_value), 5);
    chk("skip_bad_prev", 32'(bad_prev), 3);
    samp(6); samp(8);
    chk("skip_err_cnt", 32'(err_cnt), 2);
    chk("skip_hold_value", 32'(bad_value), 5);
    chk("skip_hold_code", 32'(err_code), 1);

    // Stuck across a gap; legal step across a gap
    clr();
    samp(7); idle(3); samp(7);
    chk("stuck_code", 32'(err_code), 3);
    chk("stuck_bad_value", 32'(bad_value), 7);
    clr();
    samp(7); idle(3); samp(8);
    chk("gap_legal_err", 32'(err), 0);

    // Clear with a coincident sample that must be discarded
    samp(11);
    chk("pre_clear_err", 32'(err), 1);
    saved_wcnt = int'(wrap_cnt);
    cyc(1'b1, 9, 1'b1);
    chk("clear_err", 32'(err), 0);
    chk("clear_err_cnt", 32'(err_cnt), 0);
    samp(2); samp(3);
    chk("resync_err", 32'(err), 0);
    chk("resync_wrap_cnt", 32'(wrap_cnt), saved_wcnt);

    // Random traffic: mostly legal steps, occasional jumps, gaps and clears
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) clr();
      else if (r < 20) cyc(1'b0, 0, 1'b0);
      else if (r < 28) samp(int'($urandom_range(0, 15)));
      else samp((last_v + 1) % 16);
    end

    // Drive enough legal wraps to saturate
    clr();
    samp(0);
    for (int i = 0; i < 260 * 16; i++) samp((i + 1) % 16);
    chk("wrap_sat", 32'(wrap_cnt), 255);

    // Reset in the middle of FAULT
    samp(5); samp(9);
    chk("fault_before_rst", 32'(err), 1);
    rst = 1'b1;
    cyc(1'b1, 10, 1'b0);
    rst = 1'b0;
    chk("rst_fault_err", 32'(err), 0);
    chk("rst_fault_cnt", 32'(err_cnt), 0);
    chk("rst_fault_wrap_cnt", 32'(wrap_cnt), 0);
    chk("rst_fault_bad_value", 32'(bad_value), 0);
    idle(2);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
